// File: rtl/fixture_pkg.sv
// Shared types and limits for the parametrised simulation fixture bank.
package fixture_pkg;

  typedef enum logic {
    CNT_WRAP     = 1'b0,
    CNT_SATURATE = 1'b1
  } counter_mode_e;

  localparam int unsigned MAX_DEPTH = 16;

endpackage

// File: rtl/fixture_counter_channel.sv
// One up/down counter with synchronous load and a registered terminal-count pulse.
module fixture_counter_channel
  import fixture_pkg::*;
#(
  parameter int unsigned   WIDTH = 8,
  parameter counter_mode_e MODE  = CNT_WRAP
) (
  input  logic             clk,
  input  logic             sync_rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO_VAL = '0;

  logic [WIDTH-1:0] count_nxt;
  logic             tc_nxt;

  // Next count and tc: load beats enable; a step starting at the boundary flags tc.
  always_comb begin
    count_nxt = count;
    tc_nxt    = 1'b0;
    if (load) begin
      count_nxt = load_value;
    end else if (en) begin
      if (up) begin
        if (count == MAX_VAL) begin
          tc_nxt    = 1'b1;
          count_nxt = (MODE == CNT_SATURATE) ? MAX_VAL : ZERO_VAL;
        end else begin
          count_nxt = count + WIDTH'(1);
        end
      end else begin
        if (count == ZERO_VAL) begin
          tc_nxt    = 1'b1;
          count_nxt = (MODE == CNT_SATURATE) ? ZERO_VAL : MAX_VAL;
        end else begin
          count_nxt = count - WIDTH'(1);
        end
      end
    end
  end

  // Counter and tc registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!sync_rst_n) begin
      count <= '0;
      tc    <= 1'b0;
    end else begin
      count <= count_nxt;
      tc    <= tc_nxt;
    end
  end

endmodule

// File: rtl/param_fixture_bank.sv
// Bank of independent counters plus a valid-qualified fixed-latency delay line.
module param_fixture_bank
  import fixture_pkg::*;
#(
  parameter int unsigned   CHANNELS  = 4,
  parameter int unsigned   WIDTH     = 8,
  parameter counter_mode_e MODE      = CNT_WRAP,
  parameter int unsigned   BUS_WIDTH = 48,
  parameter int unsigned   DEPTH     = 3
) (
  input  logic                      clk,
  input  logic                      sync_rst_n,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS-1:0]       up,
  input  logic [CHANNELS-1:0]       load,
  input  logic [CHANNELS*WIDTH-1:0] load_value,
  output logic [CHANNELS*WIDTH-1:0] count,
  output logic [CHANNELS-1:0]       tc,
  input  logic [BUS_WIDTH-1:0]      bus_in,
  input  logic                      bus_valid_in,
  output logic [BUS_WIDTH-1:0]      bus_out,
  output logic                      bus_valid_out
);

  // Reject out-of-range parameter sets at start of simulation.
  initial begin
    if (CHANNELS < 1 || WIDTH < 1 || WIDTH > 64 ||
        BUS_WIDTH < 1 || BUS_WIDTH > 128 || DEPTH > MAX_DEPTH) begin
      $error("param_fixture_bank: parameter out of range");
    end
  end

  // One counter channel per lane, packed into the flat count bus.
  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
    fixture_counter_channel #(
      .WIDTH (WIDTH),
      .MODE  (MODE)
    ) u_chan (
      .clk        (clk),
      .sync_rst_n (sync_rst_n),
      .en         (en[ch]),
      .up         (up[ch]),
      .load       (load[ch]),
      .load_value (load_value[ch*WIDTH +: WIDTH]),
      .count      (count[ch*WIDTH +: WIDTH]),
      .tc         (tc[ch])
    );
  end

  if (DEPTH == 0) begin : g_pass
    // Zero-latency build: straight wires, untouched by reset.
    assign bus_out       = bus_in;
    assign bus_valid_out = bus_valid_in;
  end else begin : g_pipe
    logic [BUS_WIDTH-1:0] data_q  [DEPTH];
    logic [DEPTH-1:0]     valid_q;

    // First stage captures every cycle, regardless of valid.
    always_ff @(posedge clk) begin
      if (!sync_rst_n) begin
        data_q[0]  <= '0;
        valid_q[0] <= 1'b0;
      end else begin
        data_q[0]  <= bus_in;
        valid_q[0] <= bus_valid_in;
      end
    end

    for (genvar s = 1; s < DEPTH; s++) begin : g_stage
      // Later stages shift unconditionally; reset discards in-flight entries.
      always_ff @(posedge clk) begin
        if (!sync_rst_n) begin
          data_q[s]  <= '0;
          valid_q[s] <= 1'b0;
        end else begin
          data_q[s]  <= data_q[s-1];
          valid_q[s] <= valid_q[s-1];
        end
      end
    end

    assign bus_out       = data_q[DEPTH-1];
    assign bus_valid_out = valid_q[DEPTH-1];
  end

endmodule

// File: tb/tb_param_fixture_bank.sv
// Directed checks of the fixture bank: wrap, saturate and zero-depth builds.
module tb_param_fixture_bank;
  import fixture_pkg::*;

  localparam int unsigned CH = 4;
  localparam int unsigned W  = 8;
  localparam int unsigned BW = 48;

  logic            clk = 1'b0;
  logic            sync_rst_n;
  logic [CH-1:0]   en, up, load;
  logic [CH*W-1:0] load_value;
  logic [BW-1:0]   bus_in;
  logic            bus_valid_in;

  logic [CH*W-1:0] count_w, count_s, count_z;
  logic [CH-1:0]   tc_w, tc_s, tc_z;
  logic [BW-1:0]   bus_out_w, bus_out_s, bus_out_z;
  logic            bv_w, bv_s, bv_z;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  param_fixture_bank #(.CHANNELS(CH), .WIDTH(W), .MODE(CNT_WRAP), .BUS_WIDTH(BW), .DEPTH(3)) u_wrap (
    .clk(clk), .sync_rst_n(sync_rst_n), .en(en), .up(up), .load(load), .load_value(load_value),
    .count(count_w), .tc(tc_w), .bus_in(bus_in), .bus_valid_in(bus_valid_in),
    .bus_out(bus_out_w), .bus_valid_out(bv_w));

  param_fixture_bank #(.CHANNELS(CH), .WIDTH(W), .MODE(CNT_SATURATE), .BUS_WIDTH(BW), .DEPTH(3)) u_sat (
    .clk(clk), .sync_rst_n(sync_rst_n), .en(en), .up(up), .load(load), .load_value(load_value),
    .count(count_s), .tc(tc_s), .bus_in(bus_in), .bus_valid_in(bus_valid_in),
    .bus_out(bus_out_s), .bus_valid_out(bv_s));

  param_fixture_bank #(.CHANNELS(CH), .WIDTH(W), .MODE(CNT_WRAP), .BUS_WIDTH(BW), .DEPTH(0)) u_d0 (
    .clk(clk), .sync_rst_n(sync_rst_n), .en(en), .up(up), .load(load), .load_value(load_value),
    .count(count_z), .tc(tc_z), .bus_in(bus_in), .bus_valid_in(bus_valid_in),
    .bus_out(bus_out_z), .bus_valid_out(bv_z));

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance one edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    sync_rst_n   = 1'b0;
    en           = '0;
    up           = '0;
    load         = '0;
    load_value   = '0;
    bus_in       = 48'h1234_5678_9ABC;
    bus_valid_in = 1'b1;
    #1;
    check_eq("d0_pass_in_reset_data", 128'(bus_out_z), 128'(48'h1234_5678_9ABC));
    check_eq("d0_pass_in_reset_valid", 128'(bv_z), 128'(1'b1));
    bus_valid_in = 1'b0;
    step();
    step();
    check_eq("rst_count_w", 128'(count_w), 128'(32'h0));
    check_eq("rst_tc_w", 128'(tc_w), 128'(4'h0));
    check_eq("rst_bv_w", 128'(bv_w), 128'(1'b0));
    check_eq("rst_bus_w", 128'(bus_out_w), 128'(48'h0));

    // Count up 5 cycles, reset one edge, release.
    sync_rst_n = 1'b1;
    en = 4'hF;
    up = 4'hF;
    for (int i = 0; i < 5; i++) step();
    check_eq("run5_count_w", 128'(count_w), 128'(32'h0505_0505));
    sync_rst_n = 1'b0;
    step();
    check_eq("midrst_count_w", 128'(count_w), 128'(32'h0));
    check_eq("midrst_tc_w", 128'(tc_w), 128'(4'h0));
    sync_rst_n = 1'b1;
    step();
    check_eq("post_rst_count_w", 128'(count_w), 128'(32'h0101_0101));

    // ch0 wrap from 0xFE.
    en = 4'h0;
    up = 4'h0;
    load = 4'b0001;
    load_value = 32'h0000_00FE;
    step();
    check_eq("ld0_count_w", 128'(count_w), 128'(32'h0101_01FE));
    load = 4'h0;
    en = 4'b0001;
    up = 4'b0001;
    step();
    check_eq("wrap_e1_count_w", 128'(count_w), 128'(32'h0101_01FF));
    check_eq("wrap_e1_tc_w", 128'(tc_w), 128'(4'h0));
    check_eq("sat_e1_count_s", 128'(count_s), 128'(32'h0101_01FF));
    step();
    check_eq("wrap_e2_count_w", 128'(count_w[7:0]), 128'(8'h00));
    check_eq("wrap_e2_tc_w", 128'(tc_w), 128'(4'b0001));
    check_eq("sat_e2_count_s", 128'(count_s[7:0]), 128'(8'hFF));
    check_eq("sat_e2_tc_s", 128'(tc_s), 128'(4'b0001));
    step();
    check_eq("wrap_e3_count_w", 128'(count_w), 128'(32'h0101_0101));
    check_eq("wrap_e3_tc_w", 128'(tc_w), 128'(4'h0));
    check_eq("sat_e3_tc_s", 128'(tc_s), 128'(4'b0001));

    // ch1 count down from 0x01.
    en = 4'h0;
    load = 4'b0010;
    load_value = 32'h0000_0100;
    step();
    check_eq("ld1_count_s", 128'(count_s), 128'(32'h0101_01FF));
    load = 4'h0;
    en = 4'b0010;
    up = 4'b0000;
    step();
    check_eq("dn_e1_count_s", 128'(count_s[15:8]), 128'(8'h00));
    check_eq("dn_e1_tc_s", 128'(tc_s), 128'(4'h0));
    step();
    check_eq("dn_e2_count_s", 128'(count_s[15:8]), 128'(8'h00));
    check_eq("dn_e2_tc_s", 128'(tc_s), 128'(4'b0010));
    check_eq("dn_e2_count_w", 128'(count_w[15:8]), 128'(8'hFF));
    check_eq("dn_e2_tc_w", 128'(tc_w), 128'(4'b0010));
    step();
    check_eq("dn_e3_tc_s", 128'(tc_s), 128'(4'b0010));
    check_eq("dn_e3_tc_w", 128'(tc_w), 128'(4'h0));
    step();
    check_eq("dn_e4_count_s", 128'(count_s[15:8]), 128'(8'h00));
    check_eq("dn_e4_tc_s", 128'(tc_s), 128'(4'b0010));
    up = 4'b0010;
    step();
    check_eq("up_count_s", 128'(count_s), 128'(32'h0101_01FF));
    check_eq("up_tc_s", 128'(tc_s), 128'(4'h0));
    check_eq("up_count_w", 128'(count_w), 128'(32'h0101_FE01));

    // Load beats enable on ch2; neighbours keep counting.
    en = 4'hF;
    up = 4'hF;
    load = 4'b0100;
    load_value = 32'h0080_0000;
    step();
    check_eq("prio_count_w", 128'(count_w), 128'(32'h0280_FF02));
    check_eq("prio_tc_w", 128'(tc_w), 128'(4'h0));
    check_eq("prio_count_s", 128'(count_s), 128'(32'h0280_02FF));
    check_eq("prio_tc_s", 128'(tc_s), 128'(4'b0001));
    en = 4'h0;
    load = 4'h0;

    // Single valid beat through the 3-stage line.
    bus_in = 48'hA5A5_0000_FFFF;
    bus_valid_in = 1'b1;
    #1;
    check_eq("d0_same_cycle", 128'(bus_out_z), 128'(48'hA5A5_0000_FFFF));
    step();
    check_eq("dl_e1_valid", 128'(bv_w), 128'(1'b0));
    bus_in = 48'h0;
    bus_valid_in = 1'b0;
    step();
    check_eq("dl_e2_valid", 128'(bv_w), 128'(1'b0));
    step();
    check_eq("dl_e3_valid", 128'(bv_w), 128'(1'b1));
    check_eq("dl_e3_data", 128'(bus_out_w), 128'(48'hA5A5_0000_FFFF));
    step();
    check_eq("dl_e4_valid", 128'(bv_w), 128'(1'b0));

    // Reset one edge after injecting a valid beat.
    bus_in = 48'hDEAD_BEEF_0001;
    bus_valid_in = 1'b1;
    step();
    bus_valid_in = 1'b0;
    bus_in = 48'h0F0F_F0F0_0F0F;
    sync_rst_n = 1'b0;
    #1;
    check_eq("d0_rst_track", 128'(bus_out_z), 128'(48'h0F0F_F0F0_0F0F));
    step();
    check_eq("dlrst_e1_valid", 128'(bv_w), 128'(1'b0));
    sync_rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq($sformatf("dlrst_e%0d_valid", i + 2), 128'(bv_w), 128'(1'b0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
